// File: rtl/equiv_mismatch_monitor_if.sv
// Bundle of the monitor's control inputs, sampled data and result outputs.
//
// Signals:
//   start      run request (level, sampled in IDLE)
//   clear      synchronous return to IDLE with all results cleared
//   en         sample-valid for y_1/y_2
//   y_1, y_2   outputs of the two instances under comparison
//   busy       run in progress (warm-up or compare phase)
//   done       run finished, results frozen
//   fail       sticky: at least one compared cycle mismatched
//   cmp_cnt    number of compared (post-warm-up) cycles
//   mism_cnt   number of mismatching compared cycles, saturating
//   first_idx  cmp_cnt value at the first mismatch
//   first_y1   y_1 at the first mismatch
//   first_y2   y_2 at the first mismatch
//   first_diff y_1 ^ y_2 at the first mismatch
//
// The master modport belongs to the stimulus side, the slave modport to
// the monitor.
interface equiv_mismatch_monitor_if #(
    parameter int WIDTH = 91,
    parameter int CNT_W = 32
);
    logic             start;
    logic             clear;
    logic             en;
    logic [WIDTH-1:0] y_1;
    logic [WIDTH-1:0] y_2;
    logic             busy;
    logic             done;
    logic             fail;
    logic [CNT_W-1:0] cmp_cnt;
    logic [CNT_W-1:0] mism_cnt;
    logic [CNT_W-1:0] first_idx;
    logic [WIDTH-1:0] first_y1;
    logic [WIDTH-1:0] first_y2;
    logic [WIDTH-1:0] first_diff;

    modport master (
        output start, clear, en, y_1, y_2,
        input  busy, done, fail, cmp_cnt, mism_cnt,
               first_idx, first_y1, first_y2, first_diff
    );

    modport slave (
        input  start, clear, en, y_1, y_2,
        output busy, done, fail, cmp_cnt, mism_cnt,
               first_idx, first_y1, first_y2, first_diff
    );
endinterface

// File: rtl/equiv_mismatch_monitor.sv
// Equivalence mismatch monitor.
//
// Compares two WIDTH-bit instance outputs on every enabled cycle. After
// start it discards WARMUP enabled cycles, then counts compares and
// mismatches, captures the first mismatch (index, both values, XOR diff)
// and raises a sticky fail flag. The run ends after MAX_CYCLES compares,
// or on the first mismatch when STOP_ON_FAIL=1. All results are registers.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  equiv_mismatch_monitor_if slave modport (controls, data, results)
module equiv_mismatch_monitor #(
    parameter int WIDTH        = 91,
    parameter int CNT_W        = 32,
    parameter int WARMUP       = 2,
    parameter int MAX_CYCLES   = 1000,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    equiv_mismatch_monitor_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Last warm-up count value; only meaningful when WARMUP > 0.
    localparam int WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;

    state_t           state_reg,      state_next;
    logic [CNT_W-1:0] warm_cnt_reg,   warm_cnt_next;
    logic [CNT_W-1:0] cmp_cnt_reg,    cmp_cnt_next;
    logic [CNT_W-1:0] mism_cnt_reg,   mism_cnt_next;
    logic             fail_reg,       fail_next;
    logic [CNT_W-1:0] first_idx_reg,  first_idx_next;
    logic [WIDTH-1:0] first_y1_reg,   first_y1_next;
    logic [WIDTH-1:0] first_y2_reg,   first_y2_next;
    logic [WIDTH-1:0] first_diff_reg, first_diff_next;
    logic             busy_reg,       busy_next;
    logic             done_reg,       done_next;

    logic             mismatch;
    logic [CNT_W-1:0] cmp_inc;

    always_comb begin
        state_next      = state_reg;
        warm_cnt_next   = warm_cnt_reg;
        cmp_cnt_next    = cmp_cnt_reg;
        mism_cnt_next   = mism_cnt_reg;
        fail_next       = fail_reg;
        first_idx_next  = first_idx_reg;
        first_y1_next   = first_y1_reg;
        first_y2_next   = first_y2_reg;
        first_diff_next = first_diff_reg;

        // Case inequality so that X/Z on either side counts as a mismatch
        // in simulation; synthesis treats it as ordinary inequality.
        mismatch = (bus.y_1 !== bus.y_2);
        cmp_inc  = cmp_cnt_reg + CNT_W'(1);

        if (bus.clear) begin
            state_next      = ST_IDLE;
            warm_cnt_next   = '0;
            cmp_cnt_next    = '0;
            mism_cnt_next   = '0;
            fail_next       = 1'b0;
            first_idx_next  = '0;
            first_y1_next   = '0;
            first_y2_next   = '0;
            first_diff_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        warm_cnt_next = '0;
                        state_next    = (WARMUP > 0) ? ST_WARMUP : ST_RUN;
                    end
                end
                ST_WARMUP: begin
                    if (bus.en) begin
                        warm_cnt_next = warm_cnt_reg + CNT_W'(1);
                        if (warm_cnt_reg == CNT_W'(WARM_LAST)) begin
                            state_next = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.en) begin
                        cmp_cnt_next = cmp_inc;
                        if (mismatch) begin
                            fail_next = 1'b1;
                            if (mism_cnt_reg != {CNT_W{1'b1}}) begin
                                mism_cnt_next = mism_cnt_reg + CNT_W'(1);
                            end
                            // Capture only the first mismatch of the run.
                            if (!fail_reg) begin
                                first_idx_next  = cmp_cnt_reg;
                                first_y1_next   = bus.y_1;
                                first_y2_next   = bus.y_2;
                                first_diff_next = bus.y_1 ^ bus.y_2;
                            end
                        end
                        if ((cmp_inc == CNT_W'(MAX_CYCLES)) ||
                            ((STOP_ON_FAIL != 0) && mismatch)) begin
                            state_next = ST_DONE;
                        end
                    end
                end
                default: begin
                    // DONE: results frozen until clear or rst.
                end
            endcase
        end

        // Status flags are registered copies of the next-state decode.
        busy_next = (state_next == ST_WARMUP) || (state_next == ST_RUN);
        done_next = (state_next == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            warm_cnt_reg   <= '0;
            cmp_cnt_reg    <= '0;
            mism_cnt_reg   <= '0;
            fail_reg       <= 1'b0;
            first_idx_reg  <= '0;
            first_y1_reg   <= '0;
            first_y2_reg   <= '0;
            first_diff_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            warm_cnt_reg   <= warm_cnt_next;
            cmp_cnt_reg    <= cmp_cnt_next;
            mism_cnt_reg   <= mism_cnt_next;
            fail_reg       <= fail_next;
            first_idx_reg  <= first_idx_next;
            first_y1_reg   <= first_y1_next;
            first_y2_reg   <= first_y2_next;
            first_diff_reg <= first_diff_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.fail       = fail_reg;
    assign bus.cmp_cnt    = cmp_cnt_reg;
    assign bus.mism_cnt   = mism_cnt_reg;
    assign bus.first_idx  = first_idx_reg;
    assign bus.first_y1   = first_y1_reg;
    assign bus.first_y2   = first_y2_reg;
    assign bus.first_diff = first_diff_reg;
endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// Directed testbench for equiv_mismatch_monitor.
// Three instances with different parameter sets share en/y stimulus; each
// has its own start/clear/rst, so idle instances ignore the shared data.
//   dut_a: WARMUP=2, MAX_CYCLES=8,    STOP_ON_FAIL=1
//   dut_b: WARMUP=2, MAX_CYCLES=1000, STOP_ON_FAIL=0
//   dut_c: WARMUP=0, MAX_CYCLES=4,    STOP_ON_FAIL=1
module tb_equiv_mismatch_monitor;
    localparam int W = 91;
    localparam int C = 32;

    logic clk;
    logic rst_a, rst_b, rst_c;
    logic start_a, start_b, start_c;
    logic clear_a, clear_b, clear_c;
    logic en;
    logic [W-1:0] y1, y2;
    logic [W-1:0] exp_y1, exp_diff;

    int errors = 0;
    int checks = 0;

    equiv_mismatch_monitor_if #(.WIDTH(W), .CNT_W(C)) ifa ();
    equiv_mismatch_monitor_if #(.WIDTH(W), .CNT_W(C)) ifb ();
    equiv_mismatch_monitor_if #(.WIDTH(W), .CNT_W(C)) ifc ();

    assign ifa.start = start_a;
    assign ifa.clear = clear_a;
    assign ifa.en    = en;
    assign ifa.y_1   = y1;
    assign ifa.y_2   = y2;
    assign ifb.start = start_b;
    assign ifb.clear = clear_b;
    assign ifb.en    = en;
    assign ifb.y_1   = y1;
    assign ifb.y_2   = y2;
    assign ifc.start = start_c;
    assign ifc.clear = clear_c;
    assign ifc.en    = en;
    assign ifc.y_1   = y1;
    assign ifc.y_2   = y2;

    equiv_mismatch_monitor #(.WIDTH(W), .CNT_W(C), .WARMUP(2), .MAX_CYCLES(8),
                             .STOP_ON_FAIL(1))
        dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
    equiv_mismatch_monitor #(.WIDTH(W), .CNT_W(C), .WARMUP(2), .MAX_CYCLES(1000),
                             .STOP_ON_FAIL(0))
        dut_b (.clk(clk), .rst(rst_b), .bus(ifb));
    equiv_mismatch_monitor #(.WIDTH(W), .CNT_W(C), .WARMUP(0), .MAX_CYCLES(4),
                             .STOP_ON_FAIL(1))
        dut_c (.clk(clk), .rst(rst_c), .bus(ifc));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        clear_a = 1'b0; clear_b = 1'b0; clear_c = 1'b0;
        en = 1'b0; y1 = '0; y2 = '0;
        tick(); tick();
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        check("rst_cmp", ifa.cmp_cnt, 0);
        check("rst_first_y1", ifa.first_y1, 0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();

        // ---- dut_a: warm-up masking + clean run of 8 compares ----
        start_a = 1'b1;
        tick();
        check("a_start_busy", ifa.busy, 1);
        start_a = 1'b0;
        en = 1'b1; y1 = W'(1); y2 = W'(0);
        tick(); tick();
        check("a_warm_fail", ifa.fail, 0);
        check("a_warm_mism", ifa.mism_cnt, 0);
        check("a_warm_cmp", ifa.cmp_cnt, 0);
        y1 = W'(3); y2 = W'(3);
        for (int i = 0; i < 7; i++) tick();
        check("a_7_busy", ifa.busy, 1);
        check("a_7_done", ifa.done, 0);
        check("a_7_cmp", ifa.cmp_cnt, 7);
        tick();
        check("a_8_done", ifa.done, 1);
        check("a_8_busy", ifa.busy, 0);
        check("a_8_cmp", ifa.cmp_cnt, 8);
        check("a_8_mism", ifa.mism_cnt, 0);
        check("a_8_fail", ifa.fail, 0);
        start_a = 1'b1; y1 = W'(9);
        tick();
        check("a_done_hold_cmp", ifa.cmp_cnt, 8);
        check("a_done_hold_done", ifa.done, 1);
        check("a_done_hold_fail", ifa.fail, 0);
        start_a = 1'b0;
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        check("a_clr_done", ifa.done, 0);
        check("a_clr_cmp", ifa.cmp_cnt, 0);

        // ---- dut_a: clear wins over start in IDLE ----
        clear_a = 1'b1; start_a = 1'b1;
        tick();
        check("a_clr_prio_busy", ifa.busy, 0);
        clear_a = 1'b0;

        // ---- dut_a: STOP_ON_FAIL, mismatch at compare #0 ----
        tick();                          // start_a still high: IDLE->WARMUP
        start_a = 1'b0;
        y1 = W'(0); y2 = W'(0);
        tick(); tick();
        y1 = W'('hA); y2 = W'('h2);
        tick();
        check("a_sf_done", ifa.done, 1);
        check("a_sf_fail", ifa.fail, 1);
        check("a_sf_cmp", ifa.cmp_cnt, 1);
        check("a_sf_mism", ifa.mism_cnt, 1);
        check("a_sf_idx", ifa.first_idx, 0);
        check("a_sf_y1", ifa.first_y1, 'hA);
        check("a_sf_y2", ifa.first_y2, 'h2);
        check("a_sf_diff", ifa.first_diff, 'h8);
        y1 = W'('h1); y2 = W'('h0);
        tick();
        check("a_sf_mism_hold", ifa.mism_cnt, 1);
        check("a_sf_y1_hold", ifa.first_y1, 'hA);

        // ---- dut_a: clear then rerun, MSB mismatch recaptured ----
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0;
        check("a_clr2_fail", ifa.fail, 0);
        check("a_clr2_first_y1", ifa.first_y1, 0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        y1 = W'(0); y2 = W'(0);
        tick(); tick(); tick(); tick();  // 2 warm-up + 2 equal compares
        exp_y1 = W'(7); exp_y1[W-1] = 1'b1;
        exp_diff = W'(1); exp_diff[W-1] = 1'b1;
        y1 = exp_y1; y2 = W'(6);
        tick();
        check("a_rr_done", ifa.done, 1);
        check("a_rr_idx", ifa.first_idx, 2);
        check("a_rr_y1", ifa.first_y1, exp_y1);
        check("a_rr_y2", ifa.first_y2, 6);
        check("a_rr_diff", ifa.first_diff, exp_diff);

        // ---- dut_a: asynchronous reset mid-RUN ----
        clear_a = 1'b1;
        tick();
        clear_a = 1'b0; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        y1 = W'(5); y2 = W'(5);
        for (int i = 0; i < 5; i++) tick();
        check("a_mid_cmp", ifa.cmp_cnt, 3);
        #2 rst_a = 1'b1;
        #1;
        check("a_arst_cmp", ifa.cmp_cnt, 0);
        check("a_arst_busy", ifa.busy, 0);
        #1 rst_a = 1'b0;
        tick();
        check("a_arst_idle", ifa.busy, 0);

        // ---- dut_b: first-mismatch capture, STOP_ON_FAIL=0 ----
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        en = 1'b1; y1 = W'(0); y2 = W'(0);
        tick(); tick();
        for (int i = 0; i < 1000; i++) begin
            if (i == 3) begin
                y1 = W'(5); y2 = W'(4);
            end else if (i == 5) begin
                y1 = W'('h30); y2 = W'('h31);
            end else begin
                y1 = W'(i); y2 = W'(i);
            end
            tick();
            if (i == 3) begin
                check("b_3_idx", ifb.first_idx, 3);
                check("b_3_fail", ifb.fail, 1);
                check("b_3_busy", ifb.busy, 1);
            end
            if (i == 998) check("b_998_done", ifb.done, 0);
        end
        check("b_done", ifb.done, 1);
        check("b_cmp", ifb.cmp_cnt, 1000);
        check("b_mism", ifb.mism_cnt, 2);
        check("b_fail", ifb.fail, 1);
        check("b_idx", ifb.first_idx, 3);
        check("b_y1", ifb.first_y1, 5);
        check("b_y2", ifb.first_y2, 4);
        check("b_diff", ifb.first_diff, 1);

        // ---- dut_c: WARMUP=0, en gaps, MAX_CYCLES=4 ----
        en = 1'b0; y1 = W'(2); y2 = W'(2);
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        check("c_start_busy", ifc.busy, 1);
        for (int k = 0; k < 8; k++) begin
            en = (k % 2 == 0);
            tick();
            check($sformatf("c_cmp_k%0d", k), ifc.cmp_cnt, k / 2 + 1);
            check($sformatf("c_done_k%0d", k), ifc.done, (k >= 6) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
